// File: rtl/io_port_ctrl_pkg.sv
// rtl/io_port_ctrl_pkg.sv - shared FSM, op and address definitions for the GPIO port front end
package io_port_ctrl_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } state_t;

  typedef enum logic {
    OP_SBI = 1'b0,
    OP_CBI = 1'b1
  } op_t;

  typedef enum logic [1:0] {
    TGT_PIN  = 2'd0,
    TGT_DDR  = 2'd1,
    TGT_PORT = 2'd2
  } tgt_t;

  localparam logic [5:0] PORTB_PIN_ADR  = 6'h03;
  localparam logic [5:0] PORTB_DDR_ADR  = 6'h04;
  localparam logic [5:0] PORTB_PORT_ADR = 6'h05;
  localparam logic [5:0] PORTC_PIN_ADR  = 6'h06;
  localparam logic [5:0] PORTC_DDR_ADR  = 6'h07;
  localparam logic [5:0] PORTC_PORT_ADR = 6'h08;
  localparam logic [5:0] PORTD_PIN_ADR  = 6'h09;
  localparam logic [5:0] PORTD_DDR_ADR  = 6'h0A;
  localparam logic [5:0] PORTD_PORT_ADR = 6'h0B;
  localparam logic [5:0] PORTE_PIN_ADR  = 6'h0C;
  localparam logic [5:0] PORTE_DDR_ADR  = 6'h0D;
  localparam logic [5:0] PORTE_PORT_ADR = 6'h0E;

  function automatic logic [7:0] bit_onehot(input logic [2:0] n);
    return 8'h01 << n;
  endfunction

endpackage

// File: rtl/io_port_ctrl_sync2.sv
// rtl/io_port_ctrl_sync2.sv - two-flop pad synchroniser, async reset to 0
module io_sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/io_port_ctrl.sv
// rtl/io_port_ctrl.sv - GPIO port I/O-bus decode, SBI/CBI read-modify-write, pin sync
// PORT_PCINT_EN adds the pin-change pulse output pc_event.
module io_port_ctrl
  import io_port_ctrl_pkg::*;
#(
  parameter logic [5:0] p_pin_adr   = 6'h03,
  parameter logic [5:0] p_ddr_adr   = 6'h04,
  parameter logic [5:0] p_port_adr  = 6'h05,
  parameter logic [7:0] p_impl_mask = 8'hFF
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [5:0] adr,
  input  logic       iore,
  input  logic       iowe,
  input  logic       sbi,
  input  logic       cbi,
  input  logic [2:0] bitnum,
  input  logic [7:0] dbus_in,
  output logic [7:0] dbus_out,
  output logic       out_en,
  output logic       io_stall,
  input  logic [7:0] ddr_rdata,
  input  logic [7:0] port_rdata,
  output logic [7:0] ddr_wdata,
  output logic       ddr_wbe,
  output logic [7:0] port_wdata,
  output logic       port_wbe,
  output logic       port_tog,
  input  logic [7:0] pins,
  output logic [7:0] pc_event
);

  logic [7:0] pin_sync;

  io_sync2 #(.W(8)) u_sync (
    .clk  (clk),
    .nrst (nrst),
    .d    (pins),
    .q    (pin_sync)
  );

  state_t     state, state_nxt;
  op_t        held_op;
  tgt_t       held_tgt;
  logic [7:0] held_val;
  logic [2:0] held_bit;

  logic       hit_pin, hit_ddr, hit_port, any_hit;
  logic       rmw_req;
  tgt_t       req_tgt;
  logic [7:0] req_val;
  logic [7:0] onehot;
  logic [7:0] rmw_val;
  logic [7:0] wr_data;

  assign hit_pin  = (adr == p_pin_adr);
  assign hit_ddr  = (adr == p_ddr_adr);
  assign hit_port = (adr == p_port_adr);
  assign any_hit  = hit_pin | hit_ddr | hit_port;
  assign wr_data  = dbus_in & p_impl_mask;

  // sbi and cbi together cancel each other; an OUT in the same cycle takes priority
  assign rmw_req = (state == ST_IDLE) && !iowe && (sbi ^ cbi) && any_hit;

  always_comb begin
    req_tgt = TGT_PIN;
    req_val = pin_sync;
    if (hit_ddr) begin
      req_tgt = TGT_DDR;
      req_val = ddr_rdata;
    end else if (hit_port) begin
      req_tgt = TGT_PORT;
      req_val = port_rdata;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= ST_IDLE;
      held_op  <= OP_SBI;
      held_tgt <= TGT_PIN;
      held_val <= 8'h00;
      held_bit <= 3'd0;
    end else begin
      state <= state_nxt;
      if (rmw_req) begin
        held_op  <= sbi ? OP_SBI : OP_CBI;
        held_tgt <= req_tgt;
        held_val <= req_val;
        held_bit <= bitnum;
      end
    end
  end

  assign onehot  = bit_onehot(held_bit);
  assign rmw_val = ((held_op == OP_SBI) ? (held_val | onehot) : (held_val & ~onehot)) & p_impl_mask;

  always_comb begin
    state_nxt  = state;
    io_stall   = 1'b0;
    ddr_wbe    = 1'b0;
    ddr_wdata  = 8'h00;
    port_wbe   = 1'b0;
    port_tog   = 1'b0;
    port_wdata = 8'h00;
    case (state)
      ST_IDLE: begin
        if (iowe && any_hit) begin
          if (hit_ddr) begin
            ddr_wbe   = 1'b1;
            ddr_wdata = wr_data;
          end else if (hit_port) begin
            port_wbe   = 1'b1;
            port_wdata = wr_data;
          end else begin
            port_tog   = 1'b1;
            port_wdata = wr_data;
          end
        end else if (rmw_req) begin
          io_stall  = 1'b1;
          state_nxt = ST_RMW_WR;
        end
      end
      ST_RMW_WR: begin
        state_nxt = ST_IDLE;
        case (held_tgt)
          TGT_DDR: begin
            ddr_wbe   = 1'b1;
            ddr_wdata = rmw_val;
          end
          TGT_PORT: begin
            port_wbe   = 1'b1;
            port_wdata = rmw_val;
          end
          default: begin
            // writing 1 to PINx toggles; a CBI on PINx has nothing to do
            if (held_op == OP_SBI) begin
              port_tog   = 1'b1;
              port_wdata = onehot & p_impl_mask;
            end
          end
        endcase
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    out_en   = iore & any_hit;
    dbus_out = 8'h00;
    if (iore) begin
      if (hit_ddr)       dbus_out = ddr_rdata & p_impl_mask;
      else if (hit_port) dbus_out = port_rdata & p_impl_mask;
      else if (hit_pin)  dbus_out = pin_sync & p_impl_mask;
    end
  end

`ifdef PORT_PCINT_EN
  logic [7:0] pin_prev;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pin_prev <= 8'h00;
      pc_event <= 8'h00;
    end else begin
      pin_prev <= pin_sync;
      pc_event <= (pin_sync ^ pin_prev) & p_impl_mask;
    end
  end
`else
  assign pc_event = 8'h00;
`endif

endmodule

// File: tb/tb_io_port_ctrl.sv
// tb/tb_io_port_ctrl.sv - scoreboard bench for io_port_ctrl against a register-level model
module tb_io_port_ctrl;

  localparam logic [7:0] MASK = 8'h7F;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [5:0] adr = '0;
  logic       iore = 0, iowe = 0, sbi = 0, cbi = 0;
  logic [2:0] bitnum = '0;
  logic [7:0] dbus_in = '0;
  logic [7:0] dbus_out, ddr_wdata, port_wdata, pc_event;
  logic       out_en, io_stall, ddr_wbe, port_wbe, port_tog;
  logic [7:0] pins = '0;
  logic [7:0] ddr_q = 8'h00;
  logic [7:0] port_q = 8'h00;

  always #5 clk = ~clk;

  io_port_ctrl #(
    .p_pin_adr   (6'h03),
    .p_ddr_adr   (6'h04),
    .p_port_adr  (6'h05),
    .p_impl_mask (MASK)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .adr        (adr),
    .iore       (iore),
    .iowe       (iowe),
    .sbi        (sbi),
    .cbi        (cbi),
    .bitnum     (bitnum),
    .dbus_in    (dbus_in),
    .dbus_out   (dbus_out),
    .out_en     (out_en),
    .io_stall   (io_stall),
    .ddr_rdata  (ddr_q),
    .port_rdata (port_q),
    .ddr_wdata  (ddr_wdata),
    .ddr_wbe    (ddr_wbe),
    .port_wdata (port_wdata),
    .port_wbe   (port_wbe),
    .port_tog   (port_tog),
    .pins       (pins),
    .pc_event   (pc_event)
  );

  // DDRx / PORTx register instances that the front end drives
  always @(posedge clk) begin
    if (ddr_wbe) ddr_q <= ddr_wdata;
    if (port_wbe) port_q <= port_wdata;
    else if (port_tog) port_q <= port_q ^ port_wdata;
  end

  typedef struct packed {
    logic       ddr_wbe;
    logic [7:0] ddr_wdata;
    logic       port_wbe;
    logic       port_tog;
    logic [7:0] port_wdata;
    logic       io_stall;
    logic       out_en;
    logic [7:0] dbus;
    logic [7:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // reference model state
  logic [7:0] ddr_m = 8'h00, port_m = 8'h00, pc_m = 8'h00;
  logic [7:0] hist[$];
  logic       pend_v = 0, pend_s = 0;
  logic [5:0] pend_a = '0;
  logic [2:0] pend_b = '0;
  logic [7:0] pend_val = '0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("ddr_wbe", {7'd0, ddr_wbe}, {7'd0, e.ddr_wbe});
      chk("port_wbe", {7'd0, port_wbe}, {7'd0, e.port_wbe});
      chk("port_tog", {7'd0, port_tog}, {7'd0, e.port_tog});
      chk("io_stall", {7'd0, io_stall}, {7'd0, e.io_stall});
      chk("out_en", {7'd0, out_en}, {7'd0, e.out_en});
      chk("dbus_out", dbus_out, e.dbus);
      chk("pc_event", pc_event, e.pc);
      if (e.ddr_wbe) chk("ddr_wdata", ddr_wdata, e.ddr_wdata);
      if (e.port_wbe || e.port_tog) chk("port_wdata", port_wdata, e.port_wdata);
    end
  end

  task automatic model_reset();
    hist = '{8'h00, 8'h00, 8'h00, 8'h00};
    pc_m = 8'h00;
    pend_v = 0;
  endtask

  // one bus cycle: entered and left at posedge+1
  task automatic step(input logic we, input logic re, input logic s, input logic c,
                      input logic [5:0] a, input logic [2:0] b, input logic [7:0] d);
    exp_t e;
    logic hit;
    logic [7:0] one, nd, np, dm;
    iowe = we; iore = re; sbi = s; cbi = c; adr = a; bitnum = b; dbus_in = d;
    e = '0;
    hit = (a == 6'h03) || (a == 6'h04) || (a == 6'h05);
    nd = ddr_m;
    np = port_m;
    dm = d & MASK;
    if (re && hit) begin
      e.out_en = 1'b1;
      e.dbus = ((a == 6'h04) ? ddr_m : (a == 6'h05) ? port_m : hist[1]) & MASK;
    end
    if (pend_v) begin
      pend_v = 0;
      one = 8'h01 << pend_b;
      if (pend_a == 6'h04) begin
        e.ddr_wbe = 1; e.ddr_wdata = (pend_s ? (pend_val | one) : (pend_val & ~one)) & MASK;
        nd = e.ddr_wdata;
      end else if (pend_a == 6'h05) begin
        e.port_wbe = 1; e.port_wdata = (pend_s ? (pend_val | one) : (pend_val & ~one)) & MASK;
        np = e.port_wdata;
      end else if (pend_s) begin
        e.port_tog = 1; e.port_wdata = one & MASK;
        np = port_m ^ (one & MASK);
      end
    end else if (we && hit) begin
      if (a == 6'h04) begin e.ddr_wbe = 1; e.ddr_wdata = dm; nd = dm; end
      else if (a == 6'h05) begin e.port_wbe = 1; e.port_wdata = dm; np = dm; end
      else begin e.port_tog = 1; e.port_wdata = dm; np = port_m ^ dm; end
    end else if ((s ^ c) && hit) begin
      e.io_stall = 1;
      pend_v = 1; pend_a = a; pend_s = s; pend_b = b;
      pend_val = (a == 6'h04) ? ddr_m : (a == 6'h05) ? port_m : 8'h00;
    end
    e.pc = pc_m;
    exp_q.push_back(e);
    @(posedge clk);
    ddr_m = nd;
    port_m = np;
    hist.push_front(pins);
    if (hist.size() > 6) void'(hist.pop_back());
`ifdef PORT_PCINT_EN
    pc_m = (hist[2] ^ hist[3]) & MASK;
`endif
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 6'h00, 3'd0, 8'h00);
  endtask

  initial begin
    logic [5:0] ra;
    int r;
    model_reset();
    #1;
    exp_q.push_back('0);
    @(posedge clk); @(posedge clk); #1;
    nrst = 1;

    // OUT/IN on PORTx, PINx toggle
    step(1, 0, 0, 0, 6'h05, 3'd0, 8'hA5);
    step(0, 1, 0, 0, 6'h05, 3'd0, 8'h00);
    step(1, 0, 0, 0, 6'h03, 3'd0, 8'h0F);
    step(0, 1, 0, 0, 6'h05, 3'd0, 8'h00);
    step(1, 1, 0, 0, 6'h3F, 3'd0, 8'hFF);
    // SBI DDRx bit 3, then read back
    step(0, 0, 1, 0, 6'h04, 3'd3, 8'h00);
    step(0, 0, 0, 0, 6'h00, 3'd0, 8'h00);
    step(0, 1, 0, 0, 6'h04, 3'd0, 8'h00);
    // CBI/SBI on PORTx bit 7, which is unimplemented
    step(1, 0, 0, 0, 6'h05, 3'd0, 8'hFF);
    step(0, 0, 0, 1, 6'h05, 3'd7, 8'h00);
    step(0, 1, 0, 0, 6'h05, 3'd0, 8'h00);
    step(0, 0, 1, 0, 6'h05, 3'd7, 8'h00);
    step(0, 1, 0, 0, 6'h05, 3'd0, 8'h00);
    // pin change 00 -> 81
    pins = 8'h81;
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 6'h03, 3'd0, 8'h00);
    // simultaneous requests and requests during RMW_WR
    step(1, 0, 1, 0, 6'h04, 3'd1, 8'h55);
    step(0, 0, 1, 1, 6'h04, 3'd2, 8'h00);
    step(0, 0, 0, 1, 6'h04, 3'd0, 8'h00);
    step(1, 1, 1, 0, 6'h05, 3'd4, 8'h33);
    step(0, 1, 0, 0, 6'h04, 3'd0, 8'h00);
    // SBI and CBI on PINx
    step(0, 0, 1, 0, 6'h03, 3'd2, 8'h00);
    step(0, 0, 0, 0, 6'h00, 3'd0, 8'h00);
    step(0, 0, 0, 1, 6'h03, 3'd2, 8'h00);
    step(0, 1, 0, 0, 6'h05, 3'd0, 8'h00);

    // reset while in RMW_WR: no strobe, outputs 0, DDRx untouched
    step(0, 0, 1, 0, 6'h04, 3'd6, 8'h00);
    nrst = 0;
    iowe = 0; iore = 0; sbi = 0; cbi = 0;
    model_reset();
    exp_q.push_back('0);
    @(posedge clk); #1;
    nrst = 1;
    step(0, 1, 0, 0, 6'h04, 3'd0, 8'h00);
    step(0, 0, 0, 0, 6'h04, 3'd0, 8'h00);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      case ($urandom_range(0, 3))
        0: ra = 6'h03;
        1: ra = 6'h04;
        2: ra = 6'h05;
        default: ra = 6'($urandom_range(6, 63));
      endcase
      if ($urandom_range(0, 3) == 0) pins = 8'($urandom);
      step(r < 3 || r == 7, 1'($urandom_range(0, 1)), r == 3 || r == 4 || r == 7 || r == 9,
           r == 5 || r == 6 || r == 9, ra, 3'($urandom_range(0, 7)), 8'($urandom));
    end
    idle(2);

    @(negedge clk); #1;
    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_port_ctrl.md
# io_port_ctrl

I/O-bus front end for one 8-bit GPIO port (PINx/DDRx/PORTx). It sits directly upstream of the port's two write/toggle register instances (DDRx, PORTx), and produces their `wdata`, `wbe` and `tog` strobes. It decodes CPU IN/OUT/SBI/CBI accesses and runs the two-cycle read-modify-write for SBI/CBI. It also synchronises the external pin inputs for PINx reads and returns read data to the CPU data bus.

## Interface
Parameters:
- p_pin_adr, 6'h03, I/O address of PINx
- p_ddr_adr, 6'h04, I/O address of DDRx
- p_port_adr, 6'h05, I/O address of PORTx
- p_impl_mask, 8'hFF, implemented bits; unimplemented bits read 0 and are never strobed with 1

Ports:
- Clock and reset: one clock, `clk`; reset `nrst` is asynchronous and active-low.
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- adr  in  6  I/O address
- iore  in  1  IN read strobe
- iowe  in  1  OUT write strobe
- sbi  in  1  set-bit request, single-cycle pulse
- cbi  in  1  clear-bit request, single-cycle pulse
- bitnum  in  3  bit index for sbi/cbi
- dbus_in  in  8  CPU write data
- dbus_out  out  8  read data, 0 when not selected
- out_en  out  1  read data valid (address hit with iore)
- io_stall  out  1  CPU hold during RMW read cycle
- ddr_rdata  in  8  current DDRx value
- port_rdata  in  8  current PORTx value
- ddr_wdata  out  8  DDRx write data
- ddr_wbe  out  1  DDRx write enable
- port_wdata  out  8  PORTx write/toggle data
- port_wbe  out  1  PORTx write enable
- port_tog  out  1  PORTx toggle enable (bits set in port_wdata invert)
- pins  in  8  asynchronous pad inputs
- pc_event  out  8  per-bit pin-change pulse (see Configuration)

## Operation
- State machine: IDLE, RMW_WR.
- OUT in IDLE, address hits:
  - DDRx: ddr_wbe=1, ddr_wdata=dbus_in&mask.
  - PORTx: port_wbe=1, port_wdata=dbus_in&mask.
  - PINx: port_tog=1, port_wdata=dbus_in&mask.
  - Address miss: nothing is strobed.
- IN, address hits: out_en=1.
  - dbus_out = ddr_rdata, port_rdata or pin_sync, ANDed with mask.
  - Address miss: dbus_out=0 and out_en=0.
- SBI/CBI in IDLE with address hit:
  - Capture the target register value, the op and bitnum into holding registers.
  - Assert io_stall=1 and go to RMW_WR.
- RMW_WR (one cycle):
  - Drive the target's wbe with the held value, bitnum set (SBI) or cleared (CBI); io_stall=0.
  - Return to IDLE.
- SBI on PINx: port_tog=1 with one-hot port_wdata. This happens in RMW_WR for uniform timing.
- CBI on PINx: no strobe; still takes 2 cycles.
- bitnum pointing at an unimplemented bit: write proceeds, but the masked bit stays 0.
- Simultaneous events:
  - iowe together with sbi/cbi: iowe wins, and sbi/cbi is dropped.
  - sbi and cbi together: treated as no-op, with no stall.
  - Any iowe/sbi/cbi arriving while in RMW_WR is ignored.
- Pin synchroniser: 2-flop, pin_sync = second stage.

## Timing
- OUT/toggle strobes are combinational in the request cycle; the register updates at the next clk edge.
- IN data is combinational in the same cycle.
- SBI/CBI: request cycle N has io_stall=1. In cycle N+1 the strobe is asserted, and the target value changes at the end of N+1.
- PIN read latency: a pad change is visible on dbus_out 2 clk edges later.
- Reset values: all strobes 0, dbus_out 0, out_en 0, io_stall 0, pin_sync 0, pc_event 0, state IDLE.
- Reset asserted in RMW_WR: the FSM returns to IDLE and no write strobe is emitted.

## Configuration
- PORT_PCINT_EN defined: a third flop holds the previous pin_sync, and pc_event = (pin_sync ^ prev) & mask.
  - Each pulse lasts one cycle and appears 3 edges after the pad change.
- Not defined: pc_event is tied to 8'h00 and the third flop is absent.

## Structure
- Shared package: FSM state encoding, op encoding (OP_SBI, OP_CBI) and the default port address constants for PORTB/C/D/E.
- One sub-module: io_sync2, an 8-bit 2-flop synchroniser with async reset to 0.
- The RMW and decode logic stays in io_port_ctrl.

## Test plan
- After reset, OUT 0x05 with data 8'hA5: port_wbe=1, port_wdata=8'hA5 for 1 cycle; IN 0x05 (with port_rdata=8'hA5 fed back) returns 8'hA5, out_en=1.
- OUT 0x03 with data 8'h0F while PORTx=8'hA5: port_tog=1, port_wdata=8'h0F; PORTx becomes 8'hAA.
- SBI 0x04 bit 3 with DDRx=8'h00: io_stall=1 in cycle N; ddr_wbe=1, ddr_wdata=8'h08 in N+1; then back to IDLE.
- CBI 0x05 bit 7 with PORTx=8'hFF and p_impl_mask=8'h7F: port_wdata=8'h7F; reading bit 7 returns 0.
- pins change 8'h00 to 8'h81: IN 0x03 returns 8'h81 from the second edge. With PORT_PCINT_EN, pc_event=8'h81 for exactly one cycle.
- nrst asserted during RMW_WR: no wbe or tog pulse; all outputs read 0; state is IDLE.
